// File: rtl/tennis_pkg.sv
// Shared types for the tennis rally engine.
// Holds the FSM state encoding, the ball direction encoding, the player indices,
// and a helper that gives the serve direction for a given server.
package tennis_pkg;

  typedef enum logic [1:0] {S_READY, S_FLIGHT, S_POINT, S_OVER} tennis_state_t;
  typedef enum logic {DIR_LEFT, DIR_RIGHT} ball_dir_t;

  localparam logic P_LEFT  = 1'b0;
  localparam logic P_RIGHT = 1'b1;

  // The ball always leaves the server's end heading toward the opponent
  function automatic ball_dir_t serveDir(input logic srv);
    return (srv == P_LEFT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/tennis_rally_engine_if.sv
// Player-input / display-output bundle of the tennis rally engine.
// master: button side + display side (drives swings/toss, reads display data)
// slave : the engine (reads swings/toss, drives display data)
//   swing_l, swing_r, toss : synchronised button levels, 1 = pressed
//   ball_pos               : one-hot ball location, all-0 = blank
//   server                 : 0 = left serves next, 1 = right
//   score_l, score_r       : player scores
//   speed_lvl              : current speed level
//   point_won              : 1-cycle pulse, [1] left scored, [0] right scored
//   game_over              : high while the game is over
interface tennis_rally_engine_if #(
  parameter int unsigned COURT_LEN = 8,
  parameter int unsigned SCORE_W   = 3
);

  logic                 swing_l;
  logic                 swing_r;
  logic                 toss;
  logic [COURT_LEN-1:0] ball_pos;
  logic                 server;
  logic [SCORE_W-1:0]   score_l;
  logic [SCORE_W-1:0]   score_r;
  logic [1:0]           speed_lvl;
  logic [1:0]           point_won;
  logic                 game_over;

  modport master (
    output swing_l, swing_r, toss,
    input  ball_pos, server, score_l, score_r, speed_lvl, point_won, game_over
  );

  modport slave (
    input  swing_l, swing_r, toss,
    output ball_pos, server, score_l, score_r, speed_lvl, point_won, game_over
  );

endinterface

// File: rtl/risingEdgeDetector.sv
// One-cycle pulse on a rising edge of a synchronised level.
//   CLK100MHZ  : clock
//   reset      : synchronous, active-high
//   sigIn      : synchronised input level
//   risingEdge : registered pulse, one cycle after sigIn rises
module risingEdgeDetector (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic sigIn,
  output logic risingEdge
);

  logic sigPrev;

  // During reset the history tracks the live input, so a button held through
  // reset does not fire once reset is released.
  always_ff @(posedge CLK100MHZ) begin
    sigPrev <= sigIn;
    if (reset) begin
      risingEdge <= 1'b0;
    end else begin
      risingEdge <= sigIn & ~sigPrev;
    end
  end

endmodule

// File: rtl/tennis_step_timer.sv
// Ball-step timer: ticks once every (BASE_PERIOD >> level) cycles.
//   CLK100MHZ : clock
//   reset     : synchronous, active-high
//   level     : speed level selecting the period
//   restart   : clear the count; the next tick is one full period later
//   tick_c    : combinational tick, high in the last cycle of each period
module tennis_step_timer #(
  parameter int unsigned BASE_PERIOD = 33_554_432
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [1:0] level,
  input  logic       restart,
  output logic       tick_c
);

  localparam int unsigned CNT_W = (BASE_PERIOD > 2) ? $clog2(BASE_PERIOD) : 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lastCount;

  always_comb lastCount = CNT_W'((BASE_PERIOD >> level) - 32'd1);

  // >= so a count left above a freshly shortened period wraps at once
  assign tick_c = (count >= lastCount);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      count <= '0;
    end else if (restart || tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tennis_rally_engine.sv
// Tennis game core: serve, rally, speed-up, scoring to a win.
//   CLK100MHZ : clock
//   reset     : synchronous, active-high, overrides everything
//   io        : slave side of tennis_rally_engine_if (buttons in, display data out)
module tennis_rally_engine
  import tennis_pkg::*;
#(
  parameter int unsigned COURT_LEN   = 8,
  parameter int unsigned BASE_PERIOD = 33_554_432,
  parameter int unsigned MAX_LEVEL   = 3,
  parameter int unsigned RALLY_STEP  = 2,
  parameter int unsigned POINT_HOLD  = 3,
  parameter int unsigned WIN_SCORE   = 7
) (
  input logic                  CLK100MHZ,
  input logic                  reset,
  tennis_rally_engine_if.slave io
);

  localparam int unsigned SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int unsigned RALLY_W = (RALLY_STEP > 1) ? $clog2(RALLY_STEP) : 1;
  localparam int unsigned HOLD_W  = $clog2(POINT_HOLD + 1);
  localparam logic [COURT_LEN-1:0] LEFT_END  = {1'b1, {(COURT_LEN-1){1'b0}}};
  localparam logic [COURT_LEN-1:0] RIGHT_END = COURT_LEN'(1);

  tennis_state_t        state, stateNext;
  ball_dir_t            dir, dirNext;
  logic [COURT_LEN-1:0] ballPos, ballNext;
  logic                 server, serverNext;
  logic [SCORE_W-1:0]   scoreL, scoreLNext;
  logic [SCORE_W-1:0]   scoreR, scoreRNext;
  logic [1:0]           speedLvl, speedNext;
  logic [RALLY_W-1:0]   rallyCnt, rallyNext;
  logic [HOLD_W-1:0]    holdCnt, holdNext;
  logic [1:0]           pointWon, pointWonNext;
  logic                 gameOver;

  logic swingLEdge, swingREdge, tossEdge;
  logic stepTick_c, restart_c;
  logic recvSwing, atRecvEnd, hit, lose, advance, holdDone, winReached;

  risingEdgeDetector uEdgeL (.CLK100MHZ(CLK100MHZ), .reset(reset), .sigIn(io.swing_l), .risingEdge(swingLEdge));
  risingEdgeDetector uEdgeR (.CLK100MHZ(CLK100MHZ), .reset(reset), .sigIn(io.swing_r), .risingEdge(swingREdge));
  risingEdgeDetector uEdgeT (.CLK100MHZ(CLK100MHZ), .reset(reset), .sigIn(io.toss),    .risingEdge(tossEdge));

  tennis_step_timer #(.BASE_PERIOD(BASE_PERIOD)) uTimer (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .level     (speedLvl),
    .restart   (restart_c),
    .tick_c    (stepTick_c)
  );

  // Only the receiver (the player the ball is heading toward) can hit or fault;
  // a swing from the other player never matters.
  assign recvSwing  = (dir == DIR_RIGHT) ? swingREdge : swingLEdge;
  assign atRecvEnd  = (dir == DIR_RIGHT) ? ballPos[0] : ballPos[COURT_LEN-1];
  assign hit        = (state == S_FLIGHT) && recvSwing && atRecvEnd;
  assign lose       = (state == S_FLIGHT) && (recvSwing ? !atRecvEnd : (stepTick_c && atRecvEnd));
  assign advance    = (state == S_FLIGHT) && !recvSwing && stepTick_c && !atRecvEnd;
  assign holdDone   = (state == S_POINT) && stepTick_c && (holdCnt == HOLD_W'(POINT_HOLD - 1));
  assign winReached = (scoreL == SCORE_W'(WIN_SCORE)) || (scoreR == SCORE_W'(WIN_SCORE));

  // State and datapath registers
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state    <= S_READY;
      dir      <= DIR_RIGHT;
      ballPos  <= LEFT_END;
      server   <= P_LEFT;
      scoreL   <= '0;
      scoreR   <= '0;
      speedLvl <= '0;
      rallyCnt <= '0;
      holdCnt  <= '0;
      pointWon <= '0;
      gameOver <= 1'b0;
    end else begin
      state    <= stateNext;
      dir      <= dirNext;
      ballPos  <= ballNext;
      server   <= serverNext;
      scoreL   <= scoreLNext;
      scoreR   <= scoreRNext;
      speedLvl <= speedNext;
      rallyCnt <= rallyNext;
      holdCnt  <= holdNext;
      pointWon <= pointWonNext;
      gameOver <= (stateNext == S_OVER);
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      S_READY:  if (tossEdge) stateNext = S_FLIGHT;
      S_FLIGHT: if (lose)     stateNext = S_POINT;
      S_POINT:  if (holdDone) stateNext = winReached ? S_OVER : S_READY;
      S_OVER:   if (tossEdge) stateNext = S_READY;
      default:                stateNext = S_READY;
    endcase
  end

  // Datapath next values and timer restart
  always_comb begin
    dirNext      = dir;
    ballNext     = ballPos;
    serverNext   = server;
    scoreLNext   = scoreL;
    scoreRNext   = scoreR;
    speedNext    = speedLvl;
    rallyNext    = rallyCnt;
    holdNext     = holdCnt;
    pointWonNext = 2'b00;
    restart_c    = 1'b0;
    case (state)
      S_READY: begin
        if (tossEdge) begin
          dirNext   = serveDir(server);
          restart_c = 1'b1;
        end
      end
      S_FLIGHT: begin
        if (hit) begin
          // Restart wins over a same-cycle tick, so the ball rests one full period
          dirNext   = (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
          restart_c = 1'b1;
          if (rallyCnt == RALLY_W'(RALLY_STEP - 1)) begin
            rallyNext = '0;
            if (speedLvl < 2'(MAX_LEVEL)) speedNext = speedLvl + 2'd1;
          end else begin
            rallyNext = rallyCnt + RALLY_W'(1);
          end
        end else if (lose) begin
          // The receiver lost the point, so the other side scores
          if (dir == DIR_RIGHT) begin
            pointWonNext = 2'b10;
            scoreLNext   = scoreL + SCORE_W'(1);
          end else begin
            pointWonNext = 2'b01;
            scoreRNext   = scoreR + SCORE_W'(1);
          end
          rallyNext  = '0;
          speedNext  = '0;
          serverNext = ~server;
          ballNext   = '0;
          holdNext   = '0;
          restart_c  = 1'b1;
        end else if (advance) begin
          ballNext = (dir == DIR_RIGHT) ? (ballPos >> 1) : (ballPos << 1);
        end
      end
      S_POINT: begin
        if (holdDone) begin
          if (!winReached) ballNext = (server == P_RIGHT) ? RIGHT_END : LEFT_END;
        end else if (stepTick_c) begin
          holdNext = holdCnt + HOLD_W'(1);
        end
      end
      S_OVER: begin
        if (tossEdge) begin
          scoreLNext = '0;
          scoreRNext = '0;
          serverNext = P_LEFT;
          ballNext   = LEFT_END;
        end
      end
      default: ;
    endcase
  end

  assign io.ball_pos  = ballPos;
  assign io.server    = server;
  assign io.score_l   = scoreL;
  assign io.score_r   = scoreR;
  assign io.speed_lvl = speedLvl;
  assign io.point_won = pointWon;
  assign io.game_over = gameOver;

endmodule
